// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Groups the receive handshake from uart_top and the host read port of
// uart_rx_fifo into one bundle.
//   rx_data_ready / rx_data_in / rx_clear_ready : byte handoff from the UART
//   rd_en / rd_data / empty / full / count       : host-side FIFO port
//   overrun / overrun_clear                      : sticky drop flag and its clear
// The master modport is the environment side (UART + host); the slave
// modport is the FIFO.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rx_data_ready;
    logic [7:0]        rx_data_in;
    logic              rx_clear_ready;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              overrun_clear;

    modport master (
        output rx_data_ready, rx_data_in, rd_en, overrun_clear,
        input  rx_clear_ready, rd_data, empty, full, count, overrun
    );

    modport slave (
        input  rx_data_ready, rx_data_in, rd_en, overrun_clear,
        output rx_clear_ready, rd_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive buffer behind uart_top: captures each byte presented on
// rx_data_ready/rx_data_in, acknowledges it with a one-cycle rx_clear_ready
// pulse, and stores it in a DEPTH-entry first-word-fall-through FIFO.
// Bytes arriving while the FIFO is full are dropped (still acknowledged)
// and latch the sticky overrun flag.
// Ports:
//   clk_50mhz : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : uart_rx_fifo_if.slave (UART handoff, host read port, overrun)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for rx_data_ready; captures (or drops) the byte
// ACK      | rx_clear_ready high for this single cycle
// WAIT_LOW | waiting for rx_data_ready to fall so one byte is taken once
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    uart_rx_fifo_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic              capture;
    logic              pop, push_ok, drop;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q, overrun_q, clr_q;
    logic [7:0]        mem [DEPTH];

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_data_ready) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!bus.rx_data_ready) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a byte when the head is popped in the same
    // cycle, since the freed slot and the new write land on the same edge.
    assign pop     = bus.rd_en && !empty_q;
    assign push_ok = capture && (!full_q || pop);
    assign drop    = capture && !push_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
            // Set takes priority over a same-cycle clear.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clear) begin
                overrun_q <= 1'b0;
            end
            clr_q <= capture;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_50mhz) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.rx_data_in;
        end
    end

    assign bus.rd_data        = mem[rd_ptr_q];
    assign bus.empty          = empty_q;
    assign bus.full           = full_q;
    assign bus.count          = count_q;
    assign bus.overrun        = overrun_q;
    assign bus.rx_clear_ready = clr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DEPTH=16): single byte, fill/drain with
// pointer wrap, overrun set/clear, push on full with simultaneous pop,
// held rx_data_ready, pop on empty and mid-stream reset.
module tb_uart_rx_fifo;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   ack_cnt;
    int   ack_base;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_clear_ready === 1'b1) ack_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte, hold it until acknowledged, then release and give the
    // FSM time to get back to IDLE. Called and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 0;
        bus.rx_data_ready = 1'b1;
        bus.rx_data_in    = b;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rx_clear_ready === 1'b1) seen = 1;
        end
        if (!seen) check_val("ack_timeout", 32'd0, 32'd1);
        bus.rx_data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ack_cnt  = 0;
        bus.rx_data_ready = 1'b0;
        bus.rx_data_in    = 8'h00;
        bus.rd_en         = 1'b0;
        bus.overrun_clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_empty",   32'(bus.empty), 32'd1);
        check_val("rst_full",    32'(bus.full), 32'd0);
        check_val("rst_count",   32'(bus.count), 32'd0);
        check_val("rst_overrun", 32'(bus.overrun), 32'd0);
        check_val("rst_ack",     32'(bus.rx_clear_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte
        ack_base = ack_cnt;
        send_byte(8'hA5);
        check_val("single_ack_pulses", 32'(ack_cnt - ack_base), 32'd1);
        check_val("single_count", 32'(bus.count), 32'd1);
        check_val("single_empty", 32'(bus.empty), 32'd0);
        check_val("single_data",  32'(bus.rd_data), 32'hA5);
        pop_one();
        check_val("single_pop_empty", 32'(bus.empty), 32'd1);
        check_val("single_pop_count", 32'(bus.count), 32'd0);

        // pop on empty is ignored
        pop_one();
        check_val("empty_pop_count", 32'(bus.count), 32'd0);
        check_val("empty_pop_empty", 32'(bus.empty), 32'd1);

        // fill 00..0F, check the DEPTH-1 boundary on the way
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        check_val("fill15_count", 32'(bus.count), 32'd15);
        check_val("fill15_full",  32'(bus.full), 32'd0);
        send_byte(8'h0F);
        check_val("fill_full",    32'(bus.full), 32'd1);
        check_val("fill_count",   32'(bus.count), 32'd16);
        check_val("fill_overrun", 32'(bus.overrun), 32'd0);
        check_val("fill_head",    32'(bus.rd_data), 32'h00);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("drain_%0d", i), 32'(bus.rd_data), 32'(i));
            pop_one();
        end
        check_val("drain_empty", 32'(bus.empty), 32'd1);
        check_val("drain_count", 32'(bus.count), 32'd0);
        check_val("drain_full",  32'(bus.full), 32'd0);

        // overrun on full
        fill_seq();
        ack_base = ack_cnt;
        send_byte(8'h77);
        check_val("ovr_ack_pulses", 32'(ack_cnt - ack_base), 32'd1);
        check_val("ovr_flag",  32'(bus.overrun), 32'd1);
        check_val("ovr_count", 32'(bus.count), 32'd16);
        check_val("ovr_head",  32'(bus.rd_data), 32'h00);
        bus.overrun_clear = 1'b1;
        @(negedge clk);
        bus.overrun_clear = 1'b0;
        check_val("ovr_cleared", 32'(bus.overrun), 32'd0);

        // drop and clear in the same cycle: set wins
        bus.overrun_clear = 1'b1;
        bus.rx_data_ready = 1'b1;
        bus.rx_data_in    = 8'h88;
        @(negedge clk);
        bus.overrun_clear = 1'b0;
        check_val("ovr_set_wins", 32'(bus.overrun), 32'd1);
        bus.rx_data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.overrun_clear = 1'b1;
        @(negedge clk);
        bus.overrun_clear = 1'b0;
        check_val("ovr_cleared2", 32'(bus.overrun), 32'd0);

        // push on full with simultaneous pop
        bus.rx_data_ready = 1'b1;
        bus.rx_data_in    = 8'h55;
        bus.rd_en         = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check_val("simul_ack",     32'(bus.rx_clear_ready), 32'd1);
        check_val("simul_count",   32'(bus.count), 32'd16);
        check_val("simul_overrun", 32'(bus.overrun), 32'd0);
        check_val("simul_head",    32'(bus.rd_data), 32'h01);
        bus.rx_data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            check_val($sformatf("simul_drain_%0d", i), 32'(bus.rd_data), 32'(i));
            pop_one();
        end
        check_val("simul_last", 32'(bus.rd_data), 32'h55);
        pop_one();
        check_val("simul_empty", 32'(bus.empty), 32'd1);

        // rx_data_ready held high long after the acknowledge
        ack_base = ack_cnt;
        bus.rx_data_ready = 1'b1;
        bus.rx_data_in    = 8'h6B;
        repeat (12) @(negedge clk);
        check_val("held_ack_pulses", 32'(ack_cnt - ack_base), 32'd1);
        check_val("held_count",      32'(bus.count), 32'd1);
        check_val("held_ack_low",    32'(bus.rx_clear_ready), 32'd0);
        bus.rx_data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("held_count_after", 32'(bus.count), 32'd1);
        check_val("held_data",        32'(bus.rd_data), 32'h6B);
        pop_one();
        pop_one();
        check_val("held_empty_pop", 32'(bus.count), 32'd0);

        // reset mid-stream
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        check_val("mid_count5", 32'(bus.count), 32'd5);
        bus.rx_data_ready = 1'b1;
        bus.rx_data_in    = 8'h99;
        @(negedge clk);
        check_val("mid_ack_high", 32'(bus.rx_clear_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_count",   32'(bus.count), 32'd0);
        check_val("mid_rst_empty",   32'(bus.empty), 32'd1);
        check_val("mid_rst_ack",     32'(bus.rx_clear_ready), 32'd0);
        check_val("mid_rst_overrun", 32'(bus.overrun), 32'd0);
        bus.rx_data_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h3C);
        check_val("post_rst_count", 32'(bus.count), 32'd1);
        check_val("post_rst_data",  32'(bus.rd_data), 32'h3C);
        check_val("post_rst_empty", 32'(bus.empty), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
